memory_access_controller: RTL

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

---
 rtl/memory_access_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/memory_access_controller.sv
// Decodes a byte address into one of three word-addressed memories and sequences
// a single write or read access, finishing with a one-cycle Ready (and Error) pulse.
module memory_access_controller #(
    parameter logic [31:0] BASE_1       = 32'h0000_0000,
    parameter logic [31:0] BASE_2       = 32'h0000_1000,
    parameter logic [31:0] BASE_3       = 32'h0000_2000,
    parameter int unsigned REGION_BYTES = 4096,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [9:0]  MemAddress,
    output logic [31:0] MemWriteData,
    output logic        WE_1,
    output logic        WE_2,
    output logic        WE_3,
    output logic [1:0]  MemorySelector,
    output logic        Ready,
    output logic        Error
);

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [2:0]  strobe_q, strobe_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;

    logic [2:0]  hit;
    logic [31:0] offset [3];

    // Offset is only meaningful once Address >= base, so the upper bound never overflows.
    for (genvar gi = 0; gi < 3; gi++) begin : g_region
        localparam logic [31:0] BASE = (gi == 0) ? BASE_1 : (gi == 1) ? BASE_2 : BASE_3;
        assign offset[gi] = Address - BASE;
        assign hit[gi]    = (Address >= BASE) && (offset[gi] < 32'(REGION_BYTES));
    end

    logic        dec_hit;
    logic [1:0]  dec_sel;
    logic [31:0] dec_off;
    logic        aligned;

    // Lowest-numbered region wins if parameters ever make regions overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = 2'b11;
        dec_off = '0;
        for (int i = 2; i >= 0; i--) begin
            if (hit[i]) begin
                dec_hit = 1'b1;
                dec_sel = 2'(i);
                dec_off = offset[i];
            end
        end
    end

    assign aligned = (Address[1:0] == 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        strobe_d = 3'b000;
        ready_d  = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (dec_hit && aligned) begin
                        state_d  = ACCESS;
                        wr_d     = WE;
                        sel_d    = dec_sel;
                        addr_d   = 10'(dec_off >> 2);
                        wdata_d  = WriteData;
                        strobe_d = WE ? (3'b001 << dec_sel) : 3'b000;
                    end else begin
                        state_d = ERR;
                        sel_d   = 2'b11;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(READ_LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            strobe_q <= 3'b000;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
        end
    end

    assign MemAddress     = addr_q;
    assign MemWriteData   = wdata_q;
    assign MemorySelector = sel_q;
    assign WE_1           = strobe_q[0];
    assign WE_2           = strobe_q[1];
    assign WE_3           = strobe_q[2];
    assign Ready          = ready_q;
    assign Error          = error_q;

endmodule
